// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields, flags and datapath control bundle
interface multicycle_controller_if;
  logic [5:0] op, funct;
  logic zero, memready;
  logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  modport master (
    input  op, funct, zero, memready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen,
    output alusrcb, pcsrc, alucontrol, state
  );
  modport slave (
    output op, funct, zero, memready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen,
    input  alusrcb, pcsrc, alucontrol, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle MIPS control FSM with built-in ALU-control decode
module multicycle_controller #(
  parameter bit WAIT_EN = 1'b1
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
  } state_t;
  state_t cur, dst, nxt;
  logic rdy, run, ir, mw, rw, pcw, branch;
  logic [1:0] aluop;
  logic [2:0] fdec;
  assign rdy = bus.memready | ~WAIT_EN;
  assign run = ~reset;
  // outputs decode as FETCH while reset is held
  assign dst = reset ? FETCH : cur;
  assign bus.state = cur;
  assign bus.irwrite = ir & run;
  assign bus.memwrite = mw & run;
  assign bus.regwrite = rw & run;
  assign bus.pcen = (pcw | (branch & bus.zero)) & run;
  always_ff @(posedge clk)
    cur <= reset ? FETCH : nxt;
  always_comb begin
    nxt = dst;
    bus.iord = 1'b0;
    bus.regdst = 1'b0;
    bus.memtoreg = 1'b0;
    bus.alusrca = 1'b0;
    bus.alusrcb = 2'b00;
    bus.pcsrc = 2'b00;
    aluop = 2'b00;
    ir = 1'b0;
    mw = 1'b0;
    rw = 1'b0;
    pcw = 1'b0;
    branch = 1'b0;
    case (dst)
      FETCH: begin
        bus.alusrcb = 2'b01;
        ir = rdy;
        pcw = rdy;
        nxt = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alusrcb = 2'b11;
        nxt = (bus.op == 6'b100011 || bus.op == 6'b101011) ? MEMADR :
              bus.op == 6'b000000 ? RTYPEEX :
              bus.op == 6'b000100 ? BEQEX :
              bus.op == 6'b001000 ? ADDIEX :
              bus.op == 6'b000010 ? JEX : FETCH;
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        nxt = bus.op == 6'b100011 ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.iord = 1'b1;
        nxt = rdy ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.memtoreg = 1'b1;
        rw = 1'b1;
        nxt = FETCH;
      end
      MEMWR: begin
        bus.iord = 1'b1;
        mw = 1'b1;
        nxt = rdy ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        bus.alusrca = 1'b1;
        aluop = 2'b10;
        nxt = RTYPEWB;
      end
      RTYPEWB: begin
        bus.regdst = 1'b1;
        rw = 1'b1;
        nxt = FETCH;
      end
      BEQEX: begin
        bus.alusrca = 1'b1;
        bus.pcsrc = 2'b01;
        aluop = 2'b01;
        branch = 1'b1;
        nxt = FETCH;
      end
      ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        nxt = ADDIWB;
      end
      ADDIWB: begin
        rw = 1'b1;
        nxt = FETCH;
      end
      JEX: begin
        bus.pcsrc = 2'b10;
        pcw = 1'b1;
        nxt = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end
  always_comb begin
    case (bus.funct)
      6'b100010: fdec = 3'b110;
      6'b100100: fdec = 3'b000;
      6'b100101: fdec = 3'b001;
      6'b101010: fdec = 3'b111;
      default:   fdec = 3'b010;
    endcase
    bus.alucontrol = aluop[1] ? fdec : aluop[0] ? 3'b110 : 3'b010;
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and random instruction streams against a per-signal reference table
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset;
  int cmp = 0;
  int mism = 0;
  int zm = 2;
  multicycle_controller_if bus ();
  multicycle_controller #(.WAIT_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [2:0] alu_f(input logic [5:0] f);
    return f == 6'h20 ? 3'b010 : f == 6'h22 ? 3'b110 : f == 6'h24 ? 3'b000 :
           f == 6'h25 ? 3'b001 : f == 6'h2a ? 3'b111 : 3'b010;
  endfunction
  // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,pcen,alucontrol}
  function automatic logic [14:0] ref_ctl(input int s, input logic [5:0] f, input logic z,
                                          input logic r, input logic rst);
    logic go;
    logic [2:0] ac;
    go = ~rst;
    if (rst) s = 0;
    ac = s == 6 ? alu_f(f) : s == 8 ? 3'b110 : 3'b010;
    return {s inside {3, 5}, go & (s == 5), go & r & (s == 0), s == 7, s == 4,
            go & (s inside {4, 7, 10}), s inside {2, 6, 8, 9},
            s == 0 ? 2'b01 : s == 1 ? 2'b11 : (s inside {2, 9}) ? 2'b10 : 2'b00,
            s == 8 ? 2'b01 : s == 11 ? 2'b10 : 2'b00,
            go & ((s == 0 & r) | (s == 11) | (s == 8 & z)), ac};
  endfunction
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    cmp++;
    assert (got === exp) else begin
      mism++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int s, input logic mr);
    logic z;
    logic [14:0] got;
    z = zm == 2 ? rb() : zm[0];
    bus.memready = mr;
    bus.zero = z;
    #1;
    got = {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite,
           bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen, bus.alucontrol};
    check("state", {11'b0, bus.state}, {11'b0, s[3:0]});
    check("ctrl", got, ref_ctl(s, bus.funct, z, mr, reset));
    @(posedge clk);
    #1;
  endtask
  task automatic memst(input int s, input int w);
    repeat (w) step(s, 1'b0);
    step(s, 1'b1);
  endtask
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int z,
                           input int fw, input int mw);
    bus.op = o;
    bus.funct = f;
    zm = z;
    repeat (fw) step(0, 1'b0);
    step(0, 1'b1);
    step(1, rb());
    case (o)
      6'b100011: begin step(2, rb()); memst(3, mw); step(4, rb()); end
      6'b101011: begin step(2, rb()); memst(5, mw); end
      6'b000000: begin step(6, rb()); step(7, rb()); end
      6'b000100: step(8, rb());
      6'b001000: begin step(9, rb()); step(10, rb()); end
      6'b000010: step(11, rb());
      default: ;
    endcase
  endtask
  initial begin
    logic [5:0] ops [7];
    logic [5:0] fns [5];
    logic [5:0] o, f;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    reset = 1'b1;
    bus.op = 6'b100011;
    bus.funct = 6'h00;
    bus.zero = 1'b0;
    bus.memready = 1'b1;
    @(posedge clk);
    #1;
    step(0, 1'b1);
    step(0, 1'b1);
    reset = 1'b0;
    run_instr(6'b100011, 6'h00, 2, 0, 0);
    run_instr(6'b000000, 6'b101010, 2, 0, 0);
    run_instr(6'b000100, 6'h00, 1, 0, 0);
    run_instr(6'b000100, 6'h00, 0, 0, 0);
    run_instr(6'b101011, 6'h00, 2, 3, 2);
    run_instr(6'b111111, 6'h00, 2, 0, 0);
    run_instr(6'b001000, 6'h00, 2, 1, 0);
    run_instr(6'b000010, 6'h00, 2, 0, 0);
    run_instr(6'b100011, 6'h00, 2, 2, 3);
    for (int i = 0; i < 80; i++) begin
      o = ops[$urandom_range(0, 6)];
      if (o == 6'b111111) o = 6'($urandom);
      f = rb() ? fns[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(o, f, 2, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    bus.op = 6'b100011;
    zm = 2;
    step(0, 1'b1);
    step(1, 1'b1);
    step(2, 1'b1);
    step(3, 1'b1);
    reset = 1'b1;
    step(4, 1'b1);
    reset = 1'b0;
    run_instr(6'b000000, 6'h22, 2, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
